// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline register between NPC core stages, with an
// optional one-entry skid buffer, synchronous flush and optional bubble zeroing.
module pipe_stage_reg #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SKID        = 0,
    parameter int unsigned ZERO_BUBBLE = 0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            occupancy
);

    // Encoding is {skid_valid, main_valid}.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b11
    } state_t;

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] main_data, main_next;
    logic [DATA_WIDTH-1:0] skid_data, skid_next;
    logic [DATA_WIDTH-1:0] bubble_data;
    logic                  main_valid, skid_valid;
    logic                  in_fire, out_fire;

    assign main_valid = state[0];
    assign skid_valid = state[1];

    // With a skid entry, in_ready has no combinational path from out_ready.
    assign in_ready = (SKID != 0) ? (resetn & ~flush & ~skid_valid)
                                  : (resetn & ~flush & (~main_valid | out_ready));

    assign out_valid   = main_valid;
    assign out_data    = main_data;
    assign occupancy   = {1'b0, main_valid} + {1'b0, skid_valid};
    assign in_fire     = in_valid & in_ready;
    assign out_fire    = out_valid & out_ready;
    assign bubble_data = (ZERO_BUBBLE != 0) ? '0 : main_data;

    always_comb begin
        state_next = state;
        main_next  = main_data;
        skid_next  = skid_data;
        if (flush) begin
            state_next = EMPTY;
            main_next  = bubble_data;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_next = ONE;
                        main_next  = in_data;
                    end else begin
                        main_next  = bubble_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_next  = in_data;
                    end else if (out_fire) begin
                        state_next = EMPTY;
                        main_next  = bubble_data;
                    end else if (in_fire) begin
                        state_next = TWO;
                        skid_next  = in_data;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_next = ONE;
                        main_next  = skid_data;
                    end
                end
                default: begin
                    state_next = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= EMPTY;
            main_data <= '0;
            skid_data <= '0;
        end else begin
            state     <= state_next;
            main_data <= main_next;
            skid_data <= skid_next;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and scoreboarded checks of pipe_stage_reg in three configurations:
// 0 = SKID0/ZB0, 1 = SKID1/ZB0, 2 = SKID0/ZB1.
module tb_pipe_stage_reg;

    logic        clk;
    logic        resetn;
    logic        fl    [3];
    logic        iv    [3];
    logic        ir    [3];
    logic [31:0] id    [3];
    logic        ov    [3];
    logic        ordy  [3];
    logic [31:0] od    [3];
    logic [1:0]  occ   [3];

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    pipe_stage_reg #(.DATA_WIDTH(32), .SKID(0), .ZERO_BUBBLE(0)) u_s0 (
        .clk(clk), .resetn(resetn), .flush(fl[0]),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
        .occupancy(occ[0])
    );

    pipe_stage_reg #(.DATA_WIDTH(32), .SKID(1), .ZERO_BUBBLE(0)) u_s1 (
        .clk(clk), .resetn(resetn), .flush(fl[1]),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
        .occupancy(occ[1])
    );

    pipe_stage_reg #(.DATA_WIDTH(32), .SKID(0), .ZERO_BUBBLE(1)) u_zb (
        .clk(clk), .resetn(resetn), .flush(fl[2]),
        .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]),
        .occupancy(occ[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic random_run(input int d, input int unsigned lim);
        logic [31:0] q[$];
        logic [31:0] seq;
        logic        inf, of;
        seq = 32'h100 + 32'(d) * 32'h10000;
        iv[d] = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (!iv[d] && $urandom_range(0, 3) != 0) begin
                iv[d] = 1'b1;
                id[d] = seq;
                seq++;
            end
            ordy[d] = ($urandom_range(0, 2) != 0);
            #1;
            check($sformatf("rnd%0d_occ", d), 32'(occ[d]), 32'(q.size()));
            check($sformatf("rnd%0d_occmax", d), 32'(occ[d] > 2'(lim)), 32'd0);
            inf = iv[d] & ir[d];
            of  = ov[d] & ordy[d];
            if (of) begin
                if (q.size() == 0) begin
                    check($sformatf("rnd%0d_spurious", d), od[d], 32'hFFFF_FFFF);
                end else begin
                    check($sformatf("rnd%0d_data", d), od[d], q[0]);
                    void'(q.pop_front());
                end
            end
            if (inf) q.push_back(id[d]);
            tick;
            if (inf) iv[d] = 1'b0;
        end
        iv[d]   = 1'b0;
        ordy[d] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (ov[d]) begin
                if (q.size() == 0) begin
                    check($sformatf("drain%0d_spurious", d), od[d], 32'hFFFF_FFFF);
                end else begin
                    check($sformatf("drain%0d_data", d), od[d], q[0]);
                    void'(q.pop_front());
                end
            end
            tick;
        end
        check($sformatf("drain%0d_left", d), 32'(q.size()), 32'd0);
        check($sformatf("drain%0d_occ", d), 32'(occ[d]), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b1; id[i] = 32'hDEADBEEF; ordy[i] = 1'b0; fl[i] = 1'b0;
        end
        tick;
        tick;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_ir%0d", i), 32'(ir[i]), 32'd0);
            check($sformatf("rst_ov%0d", i), 32'(ov[i]), 32'd0);
            check($sformatf("rst_od%0d", i), od[i], 32'd0);
            check($sformatf("rst_occ%0d", i), 32'(occ[i]), 32'd0);
        end
        resetn = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) check($sformatf("rel_ir%0d", i), 32'(ir[i]), 32'd1);
        tick;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("first_ov%0d", i), 32'(ov[i]), 32'd1);
            check($sformatf("first_od%0d", i), od[i], 32'hDEADBEEF);
            check($sformatf("first_occ%0d", i), 32'(occ[i]), 32'd1);
            iv[i] = 1'b0; ordy[i] = 1'b1;
        end
        tick;
        for (int i = 0; i < 3; i++) check($sformatf("drain_occ%0d", i), 32'(occ[i]), 32'd0);
        check("hold_od0", od[0], 32'hDEADBEEF);
        check("zero_od2", od[2], 32'd0);

        // Streaming through the single register
        ordy[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            iv[0] = 1'b1; id[0] = 32'(k);
            #1;
            check($sformatf("str_ir%0d", k), 32'(ir[0]), 32'd1);
            tick;
            check($sformatf("str_od%0d", k), od[0], 32'(k));
            check($sformatf("str_occ%0d", k), 32'(occ[0]), 32'd1);
        end
        iv[0] = 1'b0;
        tick;
        check("str_end_ov", 32'(ov[0]), 32'd0);

        // Backpressure into the skid entry
        ordy[1] = 1'b0; iv[1] = 1'b1; id[1] = 32'hA;
        #1; check("bp_ir_a", 32'(ir[1]), 32'd1);
        tick; check("bp_od_a", od[1], 32'hA); check("bp_occ1", 32'(occ[1]), 32'd1);
        id[1] = 32'hB;
        #1; check("bp_ir_b", 32'(ir[1]), 32'd1);
        tick; check("bp_occ2", 32'(occ[1]), 32'd2); check("bp_od_held", od[1], 32'hA);
        iv[1] = 1'b0;
        tick; check("bp_od_held2", od[1], 32'hA); check("bp_occ2b", 32'(occ[1]), 32'd2);
        ordy[1] = 1'b1;
        #1; check("bp_ir_full", 32'(ir[1]), 32'd0);
        tick; check("bp_od_b", od[1], 32'hB); check("bp_ov_b", 32'(ov[1]), 32'd1);
        check("bp_occ_b", 32'(occ[1]), 32'd1);
        tick; check("bp_ov_end", 32'(ov[1]), 32'd0); check("bp_occ_end", 32'(occ[1]), 32'd0);

        // Backpressure without skid stalls the second push
        ordy[0] = 1'b0; iv[0] = 1'b1; id[0] = 32'hC;
        tick; check("bp0_od_c", od[0], 32'hC); check("bp0_occ", 32'(occ[0]), 32'd1);
        id[0] = 32'hD;
        #1; check("bp0_ir_stall", 32'(ir[0]), 32'd0);
        tick; check("bp0_od_c2", od[0], 32'hC); check("bp0_occ2", 32'(occ[0]), 32'd1);
        ordy[0] = 1'b1;
        #1; check("bp0_ir_go", 32'(ir[0]), 32'd1);
        tick; check("bp0_od_d", od[0], 32'hD); check("bp0_ov_d", 32'(ov[0]), 32'd1);
        iv[0] = 1'b0;
        tick; check("bp0_ov_end", 32'(ov[0]), 32'd0); check("nozb_od_hold", od[0], 32'hD);

        // Flush with the skid entry full
        ordy[1] = 1'b0; iv[1] = 1'b1; id[1] = 32'h11;
        tick; id[1] = 32'h22;
        tick; check("fl_occ2", 32'(occ[1]), 32'd2);
        fl[1] = 1'b1; id[1] = 32'h33;
        #1; check("fl_ir", 32'(ir[1]), 32'd0);
        tick; check("fl_occ0", 32'(occ[1]), 32'd0); check("fl_ov0", 32'(ov[1]), 32'd0);
        fl[1] = 1'b0;
        #1; check("fl_ir_after", 32'(ir[1]), 32'd1);
        tick; check("fl_od33", od[1], 32'h33); check("fl_occ1", 32'(occ[1]), 32'd1);
        iv[1] = 1'b0; ordy[1] = 1'b1;
        tick; check("fl_drain", 32'(occ[1]), 32'd0);

        // Flush overrides a ready single register
        ordy[0] = 1'b1; iv[0] = 1'b1; id[0] = 32'h44;
        tick;
        fl[0] = 1'b1; id[0] = 32'h45;
        #1; check("fl0_ir", 32'(ir[0]), 32'd0);
        tick; check("fl0_occ", 32'(occ[0]), 32'd0); check("fl0_ov", 32'(ov[0]), 32'd0);
        check("fl0_od_hold", od[0], 32'h44);
        fl[0] = 1'b0; iv[0] = 1'b0;
        tick; check("fl0_ov_after", 32'(ov[0]), 32'd0);

        // Bubble zeroing
        ordy[2] = 1'b1; iv[2] = 1'b1; id[2] = 32'h55;
        tick; check("zb_od55", od[2], 32'h55); check("zb_ov55", 32'(ov[2]), 32'd1);
        iv[2] = 1'b0;
        tick; check("zb_od0", od[2], 32'd0); check("zb_ov0", 32'(ov[2]), 32'd0);
        ordy[2] = 1'b0; iv[2] = 1'b1; id[2] = 32'h66;
        tick; check("zb_od66", od[2], 32'h66);
        fl[2] = 1'b1; iv[2] = 1'b0;
        tick; fl[2] = 1'b0;
        check("zb_fl_od", od[2], 32'd0); check("zb_fl_occ", 32'(occ[2]), 32'd0);

        random_run(1, 2);
        random_run(0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Generic parametrised inter-stage pipeline register for the NPC core. It replaces the per-stage hand-written IF/ID, ID/EX, EX/MEM and MEM/WB registers. Signals are packed into one DATA_WIDTH bus and carried with a full valid/ready handshake on both sides. It adds an optional one-entry skid buffer (registered in_ready timing), a synchronous flush for branch/trap kill, and optional zeroing of the payload on bubbles.

Parameters:
DATA_WIDTH, 32, width of the packed stage payload (1..1024).
SKID, 0, 0 = single register (in_ready combinational from out_ready); 1 = add one skid entry (in_ready depends only on internal state).
ZERO_BUBBLE, 0, 1 = main payload register is loaded with 0 when it drains without refill; 0 = payload holds its last value.

Ports:
clk  in  1  clock, all state updates on rising edge
resetn  in  1  synchronous active-low reset
flush  in  1  kill all held entries; takes effect at the next edge
in_valid  in  1  upstream stage has a valid payload
in_ready  out  1  this block accepts the payload this cycle
in_data  in  DATA_WIDTH  upstream payload
out_valid  out  1  registered; out_data is valid
out_ready  in  1  downstream stage accepts this cycle
out_data  out  DATA_WIDTH  registered payload (main entry)
occupancy  out  2  number of held entries: 0, 1, or 2 (2 only when SKID=1)

Behaviour:
- One clock; reset is synchronous and active-low on resetn.
- Reset (resetn=0 at an edge):
  - main_valid=0, skid_valid=0, main_data=0, skid_data=0.
  - out_valid=0, out_data=0, occupancy=0.
  - in_ready is forced 0 combinationally while resetn=0.
- Handshakes:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_valid/in_data must be held by the upstream stage until in_fire; this block need not check it.
- in_ready:
  - SKID=0: resetn & ~flush & (~main_valid | out_ready).
  - SKID=1: resetn & ~flush & ~skid_valid. This has no combinational path from out_ready.
- Latency: 1 cycle. A payload accepted at edge N appears on out_data/out_valid after edge N.
- States (derived from main_valid/skid_valid):
  - EMPTY (0,0):
    - in_fire -> ONE, main<=in_data.
    - Else stay. If ZERO_BUBBLE=1, main_data<=0.
  - ONE (1,0):
    - in_fire & out_fire -> ONE, main<=in_data.
    - out_fire only -> EMPTY. If ZERO_BUBBLE=1, main_data<=0.
    - in_fire only (possible only with SKID=1) -> TWO, skid<=in_data.
    - Neither -> hold.
  - TWO (1,1), SKID=1 only:
    - in_ready=0.
    - out_fire -> ONE, main<=skid_data, skid_valid<=0.
    - Else hold.
- Flush:
  - Highest priority after reset.
  - Next state is EMPTY: main_valid, skid_valid<=0.
  - Payload registers hold, or main_data<=0 if ZERO_BUBBLE=1.
  - in_ready=0 in the flush cycle, so no payload is accepted or dropped silently.
  - out_valid is registered and not gated by flush, so an out_fire in the flush cycle is a legitimate transfer already consumed downstream.
- Ordering and integrity:
  - Payloads leave in arrival order.
  - No payload is duplicated or lost except by flush/reset.
- out_ready low indefinitely:
  - ONE holds (SKID=0), or TWO holds (SKID=1).
  - out_data stays stable while out_valid=1 & out_ready=0.
- occupancy = main_valid + skid_valid, registered-state derived.
- No arithmetic on payload; widths are pass-through. Widths of skid and main registers are both DATA_WIDTH.

Test Plan:
1. Reset: hold resetn=0 for 2 edges with in_valid=1, in_data=0xDEADBEEF -> in_ready=0, out_valid=0, out_data=0, occupancy=0; first accept on the first edge after release.
2. Streaming, SKID=0: in_valid=1 with data 1,2,3,4 on consecutive cycles, out_ready=1 -> out_data 1,2,3,4 one cycle later, in_ready=1 every cycle, occupancy=1 throughout.
3. Backpressure, SKID=1: push 0xA, 0xB with out_ready=0 -> occupancy=2, in_ready=0, out_data=0xA held. Raise out_ready -> 0xA then 0xB, no loss. Also repeat with SKID=0: the second push stalls with in_ready=0.
4. Flush with full skid: state TWO (0x11, 0x22), pulse flush=1 with in_valid=1, in_data=0x33 -> in_ready=0 that cycle, next cycle occupancy=0, out_valid=0; 0x33 accepted only after flush drops.
5. ZERO_BUBBLE=1: pass 0x55 with out_ready=1, then in_valid=0 -> cycle after drain out_data=0x0, out_valid=0. With ZERO_BUBBLE=0 out_data stays 0x55.
6. Simultaneous in_fire & out_fire in ONE (SKID=1) with random valid/ready over 1000 cycles against a scoreboard -> in-order, no duplicates, occupancy never exceeds 2; with SKID=0 it never exceeds 1.
